cpu_cmd_issuer: RTL and testbench

Synthesizable command issuer that drives the `cpu` block's register-file/ALU control pins from a valid/ready command stream and returns each result over a valid/ready response stream. It sits in front of `cpu` in place of a hand-sequenced stimulus, holding control and address fields stable across the issue window and capturing `outPut`/`over` after a fixed latency. One command is in flight at a time.

---
 rtl/cpu_cmd_issuer_if.sv | 47 ++++
 rtl/cpu_cmd_issuer.sv | 210 +++++++++++++++++++++
 tb/tb_cpu_cmd_issuer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_cmd_issuer_if.sv
// cpu_cmd_issuer_if: bundles the command stream, the response stream and the
// cpu control/result pins handled by cpu_cmd_issuer.
// The slave modport is the issuer's view. The master modport is the
// environment's view: the command source, the response sink and the cpu.
interface cpu_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_addr_a;
    logic [4:0]  cmd_addr_b;
    logic [31:0] cmd_data;

    logic [4:0]  cpu_addr_a;
    logic [4:0]  cpu_addr_b;
    logic [31:0] cpu_data_in;
    logic [1:0]  cpu_opsel;
    logic [2:0]  cpu_outsel;
    logic        cpu_asel;
    logic        cpu_bsel;
    logic        cpu_oen;
    logic [31:0] cpu_out;
    logic        cpu_over;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_over;
    logic        rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data,
        input  cpu_out, cpu_over, rsp_ready,
        output cmd_ready,
        output cpu_addr_a, cpu_addr_b, cpu_data_in, cpu_opsel, cpu_outsel,
        output cpu_asel, cpu_bsel, cpu_oen,
        output rsp_valid, rsp_data, rsp_over, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data,
        output cpu_out, cpu_over, rsp_ready,
        input  cmd_ready,
        input  cpu_addr_a, cpu_addr_b, cpu_data_in, cpu_opsel, cpu_outsel,
        input  cpu_asel, cpu_bsel, cpu_oen,
        input  rsp_valid, rsp_data, rsp_over, rsp_err
    );
endinterface

// File: rtl/cpu_cmd_issuer.sv
// cpu_cmd_issuer: accepts one command at a time, holds the decoded cpu drive
// for HOLD_CYCLES + CAPTURE_LAT cycles, then captures the cpu result and
// returns it on the response stream. All outputs are registered.
// Optional macro CPU_CMD_WRITE_ACK_EN: when defined, WRITE commands also
// return a response carrying the written data; otherwise WRITE is silent.
module cpu_cmd_issuer #(
    parameter int HOLD_CYCLES = 1,
    parameter int CAPTURE_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_cmd_issuer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [4:0]  addr_a;
        logic [4:0]  addr_b;
        logic [31:0] data_in;
        logic [1:0]  opsel;
        logic [2:0]  outsel;
        logic        asel;
        logic        bsel;
        logic        oen;
    } drive_t;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_READ  = 3'd3;
    localparam logic [2:0] OP_COMP  = 3'd4;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] WAIT_LOAD = 4'(CAPTURE_LAT - 1);

    // Non-writing read of register 0: safe to present whenever nothing is issued.
    localparam drive_t IDLE_DRIVE = '{
        addr_a:  5'd0,
        addr_b:  5'd0,
        data_in: 32'd0,
        opsel:   2'b01,
        outsel:  3'b000,
        asel:    1'b1,
        bsel:    1'b0,
        oen:     1'b0
    };

    state_t      state;
    logic [3:0]  cnt;
    logic        cmd_ready_q;
    logic        write_q;
    drive_t      drive_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_over_q;
    logic        rsp_err_q;

    function automatic drive_t decode_drive(
        input logic [2:0]  op,
        input logic [4:0]  a,
        input logic [4:0]  b,
        input logic [31:0] d
    );
        drive_t dr;
        dr     = IDLE_DRIVE;
        dr.oen = 1'b1;
        case (op)
            OP_WRITE: begin
                dr.asel    = 1'b0;
                dr.bsel    = 1'b0;
                dr.opsel   = 2'b01;
                dr.outsel  = 3'b000;
                dr.addr_a  = 5'd0;
                dr.addr_b  = b;
                dr.data_in = d;
            end
            OP_ADD, OP_SUB: begin
                dr.asel   = 1'b1;
                dr.bsel   = 1'b1;
                dr.opsel  = (op == OP_ADD) ? 2'b00 : 2'b01;
                dr.outsel = 3'b001;
                dr.addr_a = a;
                dr.addr_b = b;
            end
            OP_READ: begin
                dr.asel   = 1'b1;
                dr.bsel   = 1'b0;
                dr.opsel  = 2'b01;
                dr.outsel = 3'b000;
                dr.addr_a = a;
                dr.addr_b = a;
            end
            OP_COMP: begin
                dr.asel   = 1'b1;
                dr.bsel   = 1'b1;
                dr.opsel  = d[1:0];
                dr.outsel = 3'b100;
                dr.addr_a = a;
                dr.addr_b = b;
            end
            default: dr = IDLE_DRIVE;
        endcase
        return dr;
    endfunction

    // Command FSM: accept, hold the drive, capture the result, hand it back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cmd_ready_q <= 1'b0;
            write_q     <= 1'b0;
            drive_q     <= IDLE_DRIVE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_over_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ready_q && bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        write_q     <= (bus.cmd_op == OP_WRITE);
                        if (bus.cmd_op <= OP_COMP) begin
                            drive_q <= decode_drive(bus.cmd_op, bus.cmd_addr_a,
                                                    bus.cmd_addr_b, bus.cmd_data);
                            cnt     <= HOLD_LOAD;
                            state   <= ISSUE;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= 32'd0;
                            rsp_over_q  <= 1'b0;
                            state       <= RESP;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cnt == 4'd0) begin
                        cnt   <= WAIT_LOAD;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        drive_q <= IDLE_DRIVE;
                        if (write_q) begin
`ifdef CPU_CMD_WRITE_ACK_EN
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= drive_q.data_in;
                            rsp_over_q  <= 1'b0;
                            rsp_err_q   <= 1'b0;
                            state       <= RESP;
`else
                            cmd_ready_q <= 1'b1;
                            state       <= IDLE;
`endif
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= bus.cpu_out;
                            rsp_over_q  <= bus.cpu_over;
                            rsp_err_q   <= 1'b0;
                            state       <= RESP;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    drive_q     <= IDLE_DRIVE;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.cpu_addr_a  = drive_q.addr_a;
    assign bus.cpu_addr_b  = drive_q.addr_b;
    assign bus.cpu_data_in = drive_q.data_in;
    assign bus.cpu_opsel   = drive_q.opsel;
    assign bus.cpu_outsel  = drive_q.outsel;
    assign bus.cpu_asel    = drive_q.asel;
    assign bus.cpu_bsel    = drive_q.bsel;
    assign bus.cpu_oen     = drive_q.oen;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_over    = rsp_over_q;
    assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_cpu_cmd_issuer.sv
// tb_cpu_cmd_issuer: drives cpu_cmd_issuer with directed and random commands,
// models the cpu pins it controls, and compares responses with a
// register-file level reference. A second instance (HOLD_CYCLES=3,
// CAPTURE_LAT=2) with a fixed cpu result covers long latency and reset.
// Honours CPU_CMD_WRITE_ACK_EN if defined at compile time.
module tb_cpu_cmd_issuer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    cpu_cmd_issuer_if bus ();
    cpu_cmd_issuer_if bus3 ();

    cpu_cmd_issuer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    cpu_cmd_issuer #(
        .HOLD_CYCLES (3),
        .CAPTURE_LAT (2)
    ) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

`ifdef CPU_CMD_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    localparam logic [49:0] IDLE_VEC = {5'd0, 5'd0, 32'd0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0};

    // 10 ns clock
    always #5 clk = ~clk;

    wire [49:0] drv_now  = {bus.cpu_addr_a, bus.cpu_addr_b, bus.cpu_data_in, bus.cpu_opsel,
                            bus.cpu_outsel, bus.cpu_asel, bus.cpu_bsel, bus.cpu_oen};
    wire [49:0] drv3_now = {bus3.cpu_addr_a, bus3.cpu_addr_b, bus3.cpu_data_in, bus3.cpu_opsel,
                            bus3.cpu_outsel, bus3.cpu_asel, bus3.cpu_bsel, bus3.cpu_oen};

    assign bus3.cpu_out  = 32'h1234_5678;
    assign bus3.cpu_over = 1'b1;

    // Pin-level cpu stand-in: acts once when oen rises, registers its result
    logic [31:0] cpu_rf [32] = '{default: 32'd0};
    logic        oen_d = 1'b0;
    always @(posedge clk) begin
        logic [31:0] opa, opb, res;
        logic [32:0] wide;
        logic        ov;
        if (bus.cpu_oen && !oen_d) begin
            opa = bus.cpu_asel ? cpu_rf[bus.cpu_addr_a] : bus.cpu_data_in;
            opb = bus.cpu_bsel ? cpu_rf[bus.cpu_addr_b] : 32'd0;
            if (bus.cpu_outsel == 3'b100) begin
                case (bus.cpu_opsel)
                    2'b00:   res = {31'd0, opa == opb};
                    2'b01:   res = {31'd0, opa < opb};
                    2'b10:   res = {31'd0, opa > opb};
                    default: res = {31'd0, opa != opb};
                endcase
                ov = 1'b0;
            end else begin
                if (bus.cpu_opsel == 2'b00) wide = {1'b0, opa} + {1'b0, opb};
                else                        wide = {1'b0, opa} - {1'b0, opb};
                res = wide[31:0];
                ov  = wide[32];
                cpu_rf[bus.cpu_addr_b] <= res;
            end
            bus.cpu_out  <= res;
            bus.cpu_over <= ov;
        end
        oen_d <= bus.cpu_oen;
    end

    // Register-file level reference of what each command should return
    logic [31:0] ref_rf [32] = '{default: 32'd0};

    task automatic ref_exec(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] d, output logic has_rsp,
                            output logic [31:0] data, output logic over, output logic err);
        logic [63:0] sum;
        logic [1:0]  sel;
        has_rsp = 1'b1;
        data    = 32'd0;
        over    = 1'b0;
        err     = 1'b0;
        sel     = d[1:0];
        case (op)
            3'd0: begin
                ref_rf[b] = d;
                has_rsp   = WRITE_ACK;
                data      = d;
            end
            3'd1: begin
                sum       = 64'(ref_rf[a]) + 64'(ref_rf[b]);
                over      = (sum > 64'hFFFF_FFFF);
                data      = ref_rf[a] + ref_rf[b];
                ref_rf[b] = data;
            end
            3'd2: begin
                over      = (ref_rf[a] < ref_rf[b]);
                data      = ref_rf[a] - ref_rf[b];
                ref_rf[b] = data;
            end
            3'd3: data = ref_rf[a];
            3'd4: begin
                if (sel == 2'd0)      data = (ref_rf[a] == ref_rf[b]) ? 32'd1 : 32'd0;
                else if (sel == 2'd1) data = (ref_rf[a] <  ref_rf[b]) ? 32'd1 : 32'd0;
                else if (sel == 2'd2) data = (ref_rf[a] >  ref_rf[b]) ? 32'd1 : 32'd0;
                else                  data = (ref_rf[a] != ref_rf[b]) ? 32'd1 : 32'd0;
            end
            default: err = 1'b1;
        endcase
    endtask

    function automatic logic [49:0] exp_drive(input logic [2:0] op, input logic [4:0] a,
                                              input logic [4:0] b, input logic [31:0] d);
        logic [1:0] sel;
        sel = d[1:0];
        case (op)
            3'd0:    return {5'd0, b, d, 2'b01, 3'b000, 1'b0, 1'b0, 1'b1};
            3'd1:    return {a, b, 32'd0, 2'b00, 3'b001, 1'b1, 1'b1, 1'b1};
            3'd2:    return {a, b, 32'd0, 2'b01, 3'b001, 1'b1, 1'b1, 1'b1};
            3'd3:    return {a, a, 32'd0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b1};
            3'd4:    return {a, b, 32'd0, sel, 3'b100, 1'b1, 1'b1, 1'b1};
            default: return IDLE_VEC;
        endcase
    endfunction

    // Issues one command on the default instance and collects what came back
    task automatic send_cmd(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] d, output logic [49:0] drv, output logic got,
                            output logic [31:0] rdata, output logic rover, output logic rerr,
                            output int lat, output logic oen_any, output logic timeout);
        int n = 0;
        got = 1'b0; rdata = 32'd0; rover = 1'b0; rerr = 1'b0; lat = 0;
        oen_any = 1'b0; timeout = 1'b0; drv = '0;
        bus.cmd_op = op; bus.cmd_addr_a = a; bus.cmd_addr_b = b; bus.cmd_data = d;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            timeout = 1'b1;
            return;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        drv     = drv_now;
        oen_any = bus.cpu_oen;
        while (!bus.rsp_valid && !bus.cmd_ready && lat < 40) begin
            @(posedge clk); #1; lat++;
            oen_any |= bus.cpu_oen;
        end
        if (bus.rsp_valid) begin
            got   = 1'b1;
            rdata = bus.rsp_data;
            rover = bus.rsp_over;
            rerr  = bus.rsp_err;
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
        end else if (!bus.cmd_ready) begin
            timeout = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%b want=0", bus.cmd_ready); end
        checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_over, bus.rsp_err} !== 35'd0) begin errors++; $display("FAIL rst_rsp got=%b/%h/%b/%b want=0/0/0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_over, bus.rsp_err); end
        checks++; if (drv_now !== IDLE_VEC) begin errors++; $display("FAIL rst_drive got=%h want=%h", drv_now, IDLE_VEC); end
        checks++; if (drv3_now !== IDLE_VEC) begin errors++; $display("FAIL rst_drive3 got=%h want=%h", drv3_now, IDLE_VEC); end
        @(posedge clk); @(posedge clk); #1;
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_ready got=%b want=0", bus.cmd_ready); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", bus.cmd_ready); end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op   [8] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd2};
        logic [4:0]  t_a    [8] = '{5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd5, 5'd0, 5'd5};
        logic [4:0]  t_b    [8] = '{5'd2, 5'd0, 5'd0, 5'd5, 5'd8, 5'd8, 5'd4, 5'd4};
        logic [31:0] t_d    [8] = '{32'h5555_5555, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 32'h0};
        logic [31:0] t_want [8] = '{32'h0, 32'h0, 32'h5555_555A, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE};
        logic        t_wov  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [49:0] drv;
        logic [31:0] rdata, edata;
        logic        got, rover, rerr, oen_any, timeout, ehas, eover, eerr;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            ref_exec(t_op[i], t_a[i], t_b[i], t_d[i], ehas, edata, eover, eerr);
            send_cmd(t_op[i], t_a[i], t_b[i], t_d[i], drv, got, rdata, rover, rerr, lat, oen_any, timeout);
            checks++; if (timeout) begin errors++; $display("FAIL dir_timeout[%0d] got=timeout want=completion", i); end
            checks++; if (drv !== exp_drive(t_op[i], t_a[i], t_b[i], t_d[i])) begin errors++; $display("FAIL dir_drive[%0d] got=%h want=%h", i, drv, exp_drive(t_op[i], t_a[i], t_b[i], t_d[i])); end
            checks++; if (got !== ehas) begin errors++; $display("FAIL dir_has_rsp[%0d] got=%b want=%b", i, got, ehas); end
            checks++; if (lat != 2) begin errors++; $display("FAIL dir_latency[%0d] got=%0d want=2", i, lat); end
            if (ehas) begin
                checks++; if ({rdata, rover, rerr} !== {edata, eover, eerr}) begin errors++; $display("FAIL dir_rsp[%0d] got=%h/%b/%b want=%h/%b/%b", i, rdata, rover, rerr, edata, eover, eerr); end
            end
            if (t_op[i] != 3'd0) begin
                checks++; if ({rdata, rover} !== {t_want[i], t_wov[i]}) begin errors++; $display("FAIL dir_const[%0d] got=%h/%b want=%h/%b", i, rdata, rover, t_want[i], t_wov[i]); end
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  ops [2] = '{3'd7, 3'd5};
        logic [49:0] drv;
        logic [31:0] rdata, edata;
        logic        got, rover, rerr, oen_any, timeout, ehas, eover, eerr;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            ref_exec(ops[i], 5'd3, 5'd4, 32'hDEAD_BEEF, ehas, edata, eover, eerr);
            send_cmd(ops[i], 5'd3, 5'd4, 32'hDEAD_BEEF, drv, got, rdata, rover, rerr, lat, oen_any, timeout);
            checks++; if (got !== 1'b1 || timeout) begin errors++; $display("FAIL ill_has_rsp[%0d] got=%b want=1", i, got); end
            checks++; if ({rdata, rover, rerr} !== {edata, eover, eerr}) begin errors++; $display("FAIL ill_rsp[%0d] got=%h/%b/%b want=%h/%b/%b", i, rdata, rover, rerr, edata, eover, eerr); end
            checks++; if (oen_any !== 1'b0 || drv !== IDLE_VEC) begin errors++; $display("FAIL ill_oen[%0d] got=%b/%h want=0/%h", i, oen_any, drv, IDLE_VEC); end
            checks++; if (lat != 0) begin errors++; $display("FAIL ill_latency[%0d] got=%0d want=0", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [49:0] drv;
        logic [31:0] rdata, edata, held, wdata;
        logic        got, rover, rerr, oen_any, timeout, ehas, eover, eerr;
        int          lat, n;
        wdata = $urandom;
        ref_exec(3'd0, 5'd0, 5'd9, wdata, ehas, edata, eover, eerr);
        send_cmd(3'd0, 5'd0, 5'd9, wdata, drv, got, rdata, rover, rerr, lat, oen_any, timeout);
        checks++; if (timeout) begin errors++; $display("FAIL b2b_write got=timeout want=completion"); end
        ref_exec(3'd3, 5'd9, 5'd0, 32'd0, ehas, edata, eover, eerr);
        bus.cmd_op = 3'd3; bus.cmd_addr_a = 5'd9; bus.cmd_addr_b = 5'd0; bus.cmd_data = 32'd0;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.cmd_op = 3'd1; bus.cmd_addr_a = 5'd9; bus.cmd_addr_b = 5'd9; bus.cmd_data = 32'd0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_valid got=%b want=1", bus.rsp_valid); end
        held = bus.rsp_data;
        checks++; if (held !== edata) begin errors++; $display("FAIL b2b_read_data got=%h want=%h", held, edata); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if ({bus.rsp_valid, bus.rsp_data, bus.cmd_ready, bus.cpu_oen} !== {1'b1, held, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_hold[%0d] got=%b/%h/%b/%b want=1/%h/0/0", i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, bus.cpu_oen, held); end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        checks++; if ({bus.rsp_valid, bus.cmd_ready, bus.cpu_oen} !== 3'b010) begin errors++; $display("FAIL b2b_release got=%b%b%b want=010", bus.rsp_valid, bus.cmd_ready, bus.cpu_oen); end
        ref_exec(3'd1, 5'd9, 5'd9, 32'd0, ehas, edata, eover, eerr);
        send_cmd(3'd1, 5'd9, 5'd9, 32'd0, drv, got, rdata, rover, rerr, lat, oen_any, timeout);
        checks++; if ({got, rdata, rover, rerr} !== {1'b1, edata, eover, eerr}) begin errors++; $display("FAIL b2b_next got=%b/%h/%b/%b want=1/%h/%b/%b", got, rdata, rover, rerr, edata, eover, eerr); end
    endtask

    task automatic test_write_ack();
        logic [49:0] drv;
        logic [31:0] rdata, edata;
        logic        got, rover, rerr, oen_any, timeout, ehas, eover, eerr;
        int          lat;
        ref_exec(3'd0, 5'd0, 5'd3, 32'hA, ehas, edata, eover, eerr);
        send_cmd(3'd0, 5'd0, 5'd3, 32'hA, drv, got, rdata, rover, rerr, lat, oen_any, timeout);
        checks++; if (timeout || got !== WRITE_ACK) begin errors++; $display("FAIL wack_has_rsp got=%b want=%b", got, WRITE_ACK); end
        checks++; if (lat != 2) begin errors++; $display("FAIL wack_latency got=%0d want=2", lat); end
        if (WRITE_ACK) begin
            checks++; if ({rdata, rover, rerr} !== {32'hA, 1'b0, 1'b0}) begin errors++; $display("FAIL wack_rsp got=%h/%b/%b want=0000000a/0/0", rdata, rover, rerr); end
        end
        ref_exec(3'd3, 5'd3, 5'd0, 32'd0, ehas, edata, eover, eerr);
        send_cmd(3'd3, 5'd3, 5'd0, 32'd0, drv, got, rdata, rover, rerr, lat, oen_any, timeout);
        checks++; if ({got, rdata} !== {1'b1, 32'hA}) begin errors++; $display("FAIL wack_readback got=%b/%h want=1/0000000a", got, rdata); end
    endtask

    task automatic test_random();
        logic [49:0] drv;
        logic [31:0] rdata, edata, d;
        logic        got, rover, rerr, oen_any, timeout, ehas, eover, eerr;
        logic [2:0]  op;
        logic [4:0]  a, b;
        int          lat, elat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 5'($urandom_range(0, 7));
            b  = 5'($urandom_range(0, 7));
            d  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            ref_exec(op, a, b, d, ehas, edata, eover, eerr);
            elat = (op > 3'd4) ? 0 : 2;
            send_cmd(op, a, b, d, drv, got, rdata, rover, rerr, lat, oen_any, timeout);
            checks++; if (timeout || got !== ehas || lat != elat) begin errors++; $display("FAIL rnd_flow[%0d] op=%0d got=%b/%0d want=%b/%0d", i, op, got, lat, ehas, elat); end
            checks++; if (drv !== exp_drive(op, a, b, d)) begin errors++; $display("FAIL rnd_drive[%0d] op=%0d got=%h want=%h", i, op, drv, exp_drive(op, a, b, d)); end
            if (ehas) begin
                checks++; if ({rdata, rover, rerr} !== {edata, eover, eerr}) begin errors++; $display("FAIL rnd_rsp[%0d] op=%0d got=%h/%b/%b want=%h/%b/%b", i, op, rdata, rover, rerr, edata, eover, eerr); end
            end
        end
    endtask

    task automatic test_long_latency();
        int n = 0;
        int lat = 0;
        bus3.cmd_op = 3'd1; bus3.cmd_addr_a = 5'd1; bus3.cmd_addr_b = 5'd2; bus3.cmd_data = 32'd0;
        bus3.cmd_valid = 1'b1;
        while (!bus3.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus3.cmd_valid = 1'b0;
        while (!bus3.rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (lat == 4) begin
                checks++; if (drv3_now !== exp_drive(3'd1, 5'd1, 5'd2, 32'd0)) begin errors++; $display("FAIL long_drive_held got=%h want=%h", drv3_now, exp_drive(3'd1, 5'd1, 5'd2, 32'd0)); end
            end
        end
        checks++; if (lat != 5) begin errors++; $display("FAIL long_latency got=%0d want=5", lat); end
        checks++; if ({bus3.rsp_data, bus3.rsp_over, bus3.rsp_err, drv3_now} !== {32'h1234_5678, 1'b1, 1'b0, IDLE_VEC}) begin errors++; $display("FAIL long_rsp got=%h/%b/%b/%h want=12345678/1/0/%h", bus3.rsp_data, bus3.rsp_over, bus3.rsp_err, drv3_now, IDLE_VEC); end
        bus3.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus3.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        int n = 0;
        logic seen_valid = 1'b0;
        logic seen_oen = 1'b0;
        bus3.cmd_op = 3'd2; bus3.cmd_addr_a = 5'd6; bus3.cmd_addr_b = 5'd7; bus3.cmd_data = 32'd0;
        bus3.cmd_valid = 1'b1;
        while (!bus3.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus3.cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (drv3_now !== exp_drive(3'd2, 5'd6, 5'd7, 32'd0)) begin errors++; $display("FAIL rmid_drive got=%h want=%h", drv3_now, exp_drive(3'd2, 5'd6, 5'd7, 32'd0)); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({drv3_now, bus3.cmd_ready, bus3.rsp_valid} !== {IDLE_VEC, 1'b0, 1'b0}) begin errors++; $display("FAIL rmid_async got=%h/%b/%b want=%h/0/0", drv3_now, bus3.cmd_ready, bus3.rsp_valid, IDLE_VEC); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus3.cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b want=1", bus3.cmd_ready); end
        for (int i = 0; i < 8; i++) begin
            seen_valid |= bus3.rsp_valid;
            seen_oen   |= bus3.cpu_oen;
            @(posedge clk); #1;
        end
        checks++; if ({seen_valid, seen_oen} !== 2'b00) begin errors++; $display("FAIL rmid_dropped got=%b%b want=00", seen_valid, seen_oen); end
    endtask

    // Safety net so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.cmd_op = 3'd0; bus.cmd_addr_a = 5'd0; bus.cmd_addr_b = 5'd0; bus.cmd_data = 32'd0;
        bus3.cmd_valid = 1'b0; bus3.rsp_ready = 1'b0;
        bus3.cmd_op = 3'd0; bus3.cmd_addr_a = 5'd0; bus3.cmd_addr_b = 5'd0; bus3.cmd_data = 32'd0;
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_write_ack();
        test_random();
        test_long_latency();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
